// File: rtl/llc_mem_serdes_pkg.sv
// Shared types and constants for the LLC <-> memory-controller line/beat converter.
package llc_mem_serdes_pkg;

   localparam int DEF_WORDS_PER_LINE = 4;

   // hsize of one 64-bit memory beat
   localparam logic [2:0] WORD_HSIZE = 3'b011;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_REQ,
      RD_DATA,
      RD_RSP
   } state_t;

   typedef logic [$clog2(DEF_WORDS_PER_LINE)-1:0] beat_idx_t;

endpackage

// File: rtl/llc_mem_line_buf.sv
// Line register shared by both directions: whole-line load for writes,
// per-word fill for reads, and a word-select mux feeding the write beats.
module llc_mem_line_buf
   import llc_mem_serdes_pkg::*;
#(
   parameter int WORD_BITS      = 64,
   parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   parameter int IDX_BITS       = $clog2(WORDS_PER_LINE)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                load_en,
   input  logic [WORD_BITS*WORDS_PER_LINE-1:0] load_line,
   input  logic                                wr_en,
   input  logic [IDX_BITS-1:0]                 wr_idx,
   input  logic [WORD_BITS-1:0]                wr_word,
   input  logic [IDX_BITS-1:0]                 rd_idx,
   output logic [WORD_BITS-1:0]                rd_word,
   output logic [WORD_BITS*WORDS_PER_LINE-1:0] line
);

   logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0] words;

   // A load and a word write never coincide; the load wins if they ever did.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         words <= '0;
      end else if (load_en) begin
         words <= load_line;
      end else if (wr_en) begin
         words[wr_idx] <= wr_word;
      end
   end

   assign rd_word = words[rd_idx];
   assign line    = words;

endmodule

// File: rtl/llc_mem_serdes.sv
// Splits LLC line writes into word beats and gathers word read beats into a line.
// Optional transaction counters are built when LLC_MEM_SERDES_STATS_EN is defined.
module llc_mem_serdes
   import llc_mem_serdes_pkg::*;
#(
   parameter int WORD_BITS      = 64,
   parameter int WORDS_PER_LINE = 4,
   parameter int LINE_ADDR_BITS = 26,
   parameter int BYTE_ADDR_BITS = LINE_ADDR_BITS + $clog2(WORDS_PER_LINE) + $clog2(WORD_BITS/8)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                llc_mem_req_valid,
   output logic                                llc_mem_req_ready,
   input  logic                                llc_mem_req_data_hwrite,
   input  logic [2:0]                          llc_mem_req_data_hsize,
   input  logic [1:0]                          llc_mem_req_data_hprot,
   input  logic [LINE_ADDR_BITS-1:0]           llc_mem_req_data_addr,
   input  logic [WORD_BITS*WORDS_PER_LINE-1:0] llc_mem_req_data_line,
   output logic                                llc_mem_rsp_valid,
   input  logic                                llc_mem_rsp_ready,
   output logic [WORD_BITS*WORDS_PER_LINE-1:0] llc_mem_rsp_data_line,
   output logic                                mem_req_valid,
   input  logic                                mem_req_ready,
   output logic                                mem_req_hwrite,
   output logic [2:0]                          mem_req_hsize,
   output logic [1:0]                          mem_req_hprot,
   output logic [BYTE_ADDR_BITS-1:0]           mem_req_addr,
   output logic [WORD_BITS-1:0]                mem_req_wdata,
   output logic                                mem_req_last,
   input  logic                                mem_rsp_valid,
   output logic                                mem_rsp_ready,
   input  logic [WORD_BITS-1:0]                mem_rsp_data,
   output logic [31:0]                         stat_rd_cnt,
   output logic [31:0]                         stat_wr_cnt
);

   localparam int LINE_BITS = WORD_BITS * WORDS_PER_LINE;
   localparam int IDX_BITS  = $clog2(WORDS_PER_LINE);
   localparam int OFF_BITS  = $clog2(WORD_BITS / 8);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS_PER_LINE - 1);
   localparam logic [2:0] BEAT_HSIZE = (WORD_BITS == 64) ? WORD_HSIZE : 3'(OFF_BITS);

   state_t                    state, state_next;
   logic [IDX_BITS-1:0]       idx, idx_next;
   logic [LINE_ADDR_BITS-1:0] addr_q, cur_addr;
   logic [2:0]                hsize_q, cur_hsize;
   logic [1:0]                hprot_q, cur_hprot;
   logic                      req_hs, beat_hs, rsp_hs, line_hs;
   logic                      buf_load, buf_wr, wr_done;
   logic [WORD_BITS-1:0]      buf_rd_word;
   logic [LINE_BITS-1:0]      buf_line;

   logic                      req_valid_n, hwrite_n, last_n;
   logic [2:0]                hsize_n;
   logic [1:0]                hprot_n;
   logic [BYTE_ADDR_BITS-1:0] addr_n;
   logic [WORD_BITS-1:0]      wdata_n;

   assign req_hs  = llc_mem_req_valid && llc_mem_req_ready;
   assign beat_hs = mem_req_valid && mem_req_ready;
   assign rsp_hs  = mem_rsp_valid && mem_rsp_ready;
   assign line_hs = llc_mem_rsp_valid && llc_mem_rsp_ready;
   assign wr_done = (state == WR) && beat_hs && (idx == LAST_IDX);

   // Next state, beat index and line-buffer controls.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      buf_load   = 1'b0;
      buf_wr     = 1'b0;
      case (state)
         IDLE: begin
            if (req_hs) begin
               buf_load   = 1'b1;
               idx_next   = '0;
               state_next = llc_mem_req_data_hwrite ? WR : RD_REQ;
            end
         end
         WR: begin
            if (beat_hs) begin
               idx_next = idx + 1'b1;
               if (idx == LAST_IDX) state_next = IDLE;
            end
         end
         RD_REQ: begin
            if (beat_hs) state_next = RD_DATA;
         end
         RD_DATA: begin
            if (rsp_hs) begin
               buf_wr   = 1'b1;
               idx_next = idx + 1'b1;
               if (idx == LAST_IDX) state_next = RD_RSP;
            end
         end
         RD_RSP: begin
            if (line_hs) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request fields are computed one cycle ahead so every output leaves a flop;
   // on the capture cycle the buffer is not loaded yet, so bypass the inputs.
   always_comb begin
      cur_addr    = buf_load ? llc_mem_req_data_addr  : addr_q;
      cur_hsize   = buf_load ? llc_mem_req_data_hsize : hsize_q;
      cur_hprot   = buf_load ? llc_mem_req_data_hprot : hprot_q;
      req_valid_n = (state_next == WR) || (state_next == RD_REQ);
      hwrite_n    = (state_next == WR);
      hsize_n     = '0;
      hprot_n     = '0;
      addr_n      = '0;
      wdata_n     = '0;
      last_n      = 1'b0;
      if (state_next == WR) begin
         hsize_n = BEAT_HSIZE;
         hprot_n = cur_hprot;
         addr_n  = {cur_addr, idx_next, {OFF_BITS{1'b0}}};
         wdata_n = buf_load ? llc_mem_req_data_line[WORD_BITS-1:0] : buf_rd_word;
         last_n  = (idx_next == LAST_IDX);
      end else if (state_next == RD_REQ) begin
         hsize_n = cur_hsize;
         hprot_n = cur_hprot;
         addr_n  = {cur_addr, {IDX_BITS{1'b0}}, {OFF_BITS{1'b0}}};
         last_n  = 1'b1;
      end
   end

   // FSM state, beat index and captured request attributes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         idx     <= '0;
         addr_q  <= '0;
         hsize_q <= '0;
         hprot_q <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         if (buf_load) begin
            addr_q  <= llc_mem_req_data_addr;
            hsize_q <= llc_mem_req_data_hsize;
            hprot_q <= llc_mem_req_data_hprot;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         llc_mem_req_ready <= 1'b1;
         llc_mem_rsp_valid <= 1'b0;
         mem_rsp_ready     <= 1'b0;
         mem_req_valid     <= 1'b0;
         mem_req_hwrite    <= 1'b0;
         mem_req_hsize     <= '0;
         mem_req_hprot     <= '0;
         mem_req_addr      <= '0;
         mem_req_wdata     <= '0;
         mem_req_last      <= 1'b0;
      end else begin
         llc_mem_req_ready <= (state_next == IDLE);
         llc_mem_rsp_valid <= (state_next == RD_RSP);
         mem_rsp_ready     <= (state_next == RD_DATA);
         mem_req_valid     <= req_valid_n;
         mem_req_hwrite    <= hwrite_n;
         mem_req_hsize     <= hsize_n;
         mem_req_hprot     <= hprot_n;
         mem_req_addr      <= addr_n;
         mem_req_wdata     <= wdata_n;
         mem_req_last      <= last_n;
      end
   end

   llc_mem_line_buf #(
      .WORD_BITS      (WORD_BITS),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .IDX_BITS       (IDX_BITS)
   ) u_line_buf (
      .clk       (clk),
      .rst       (rst),
      .load_en   (buf_load),
      .load_line (llc_mem_req_data_line),
      .wr_en     (buf_wr),
      .wr_idx    (idx),
      .wr_word   (mem_rsp_data),
      .rd_idx    (idx_next),
      .rd_word   (buf_rd_word),
      .line      (buf_line)
   );

   assign llc_mem_rsp_data_line = buf_line;

`ifdef LLC_MEM_SERDES_STATS_EN
   logic [31:0] rd_cnt, wr_cnt;

   // Saturating counters of completed line reads and line writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (line_hs && (rd_cnt != 32'hFFFF_FFFF)) rd_cnt <= rd_cnt + 32'd1;
         if (wr_done && (wr_cnt != 32'hFFFF_FFFF)) wr_cnt <= wr_cnt + 32'd1;
      end
   end

   assign stat_rd_cnt = rd_cnt;
   assign stat_wr_cnt = wr_cnt;
`else
   logic unused_stats;
   assign unused_stats = wr_done;
   assign stat_rd_cnt  = '0;
   assign stat_wr_cnt  = '0;
`endif

endmodule

// File: tb/tb_llc_mem_serdes.sv
// Randomized self-checking bench for llc_mem_serdes: an in-bench memory model
// serves beats with random stalls/gaps and each line is checked against plain arithmetic.
module tb_llc_mem_serdes;

   localparam int WORD_BITS      = 64;
   localparam int WORDS_PER_LINE = 4;
   localparam int LINE_ADDR_BITS = 26;
   localparam int BYTE_ADDR_BITS = 31;
   localparam int LINE_BITS      = WORD_BITS * WORDS_PER_LINE;

   typedef logic [LINE_BITS-1:0] val_t;

   logic                      clk;
   logic                      rst;
   logic                      llc_mem_req_valid;
   logic                      llc_mem_req_ready;
   logic                      llc_mem_req_data_hwrite;
   logic [2:0]                llc_mem_req_data_hsize;
   logic [1:0]                llc_mem_req_data_hprot;
   logic [LINE_ADDR_BITS-1:0] llc_mem_req_data_addr;
   logic [LINE_BITS-1:0]      llc_mem_req_data_line;
   logic                      llc_mem_rsp_valid;
   logic                      llc_mem_rsp_ready;
   logic [LINE_BITS-1:0]      llc_mem_rsp_data_line;
   logic                      mem_req_valid;
   logic                      mem_req_ready;
   logic                      mem_req_hwrite;
   logic [2:0]                mem_req_hsize;
   logic [1:0]                mem_req_hprot;
   logic [BYTE_ADDR_BITS-1:0] mem_req_addr;
   logic [WORD_BITS-1:0]      mem_req_wdata;
   logic                      mem_req_last;
   logic                      mem_rsp_valid;
   logic                      mem_rsp_ready;
   logic [WORD_BITS-1:0]      mem_rsp_data;
   logic [31:0]               stat_rd_cnt;
   logic [31:0]               stat_wr_cnt;

   int compareCount  = 0;
   int mismatchCount = 0;
   int expWrCnt      = 0;
   int expRdCnt      = 0;

   llc_mem_serdes #(
      .WORD_BITS      (WORD_BITS),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .LINE_ADDR_BITS (LINE_ADDR_BITS),
      .BYTE_ADDR_BITS (BYTE_ADDR_BITS)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .llc_mem_req_valid       (llc_mem_req_valid),
      .llc_mem_req_ready       (llc_mem_req_ready),
      .llc_mem_req_data_hwrite (llc_mem_req_data_hwrite),
      .llc_mem_req_data_hsize  (llc_mem_req_data_hsize),
      .llc_mem_req_data_hprot  (llc_mem_req_data_hprot),
      .llc_mem_req_data_addr   (llc_mem_req_data_addr),
      .llc_mem_req_data_line   (llc_mem_req_data_line),
      .llc_mem_rsp_valid       (llc_mem_rsp_valid),
      .llc_mem_rsp_ready       (llc_mem_rsp_ready),
      .llc_mem_rsp_data_line   (llc_mem_rsp_data_line),
      .mem_req_valid           (mem_req_valid),
      .mem_req_ready           (mem_req_ready),
      .mem_req_hwrite          (mem_req_hwrite),
      .mem_req_hsize           (mem_req_hsize),
      .mem_req_hprot           (mem_req_hprot),
      .mem_req_addr            (mem_req_addr),
      .mem_req_wdata           (mem_req_wdata),
      .mem_req_last            (mem_req_last),
      .mem_rsp_valid           (mem_rsp_valid),
      .mem_rsp_ready           (mem_rsp_ready),
      .mem_rsp_data            (mem_rsp_data),
      .stat_rd_cnt             (stat_rd_cnt),
      .stat_wr_cnt             (stat_wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input val_t observed, input val_t expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic val_t randLine();
      val_t l;
      for (int k = 0; k < LINE_BITS / 32; k++) l[k*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic val_t expStatWr();
`ifdef LLC_MEM_SERDES_STATS_EN
      return val_t'(expWrCnt);
`else
      return '0;
`endif
   endfunction

   function automatic val_t expStatRd();
`ifdef LLC_MEM_SERDES_STATS_EN
      return val_t'(expRdCnt);
`else
      return '0;
`endif
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, val_t'(llc_mem_req_ready), val_t'(1));
      checkOutput({tag, "_rsp_valid"}, val_t'(llc_mem_rsp_valid), '0);
      checkOutput({tag, "_rsp_line"},  val_t'(llc_mem_rsp_data_line), '0);
      checkOutput({tag, "_mreq_valid"}, val_t'(mem_req_valid), '0);
      checkOutput({tag, "_mreq_hwrite"}, val_t'(mem_req_hwrite), '0);
      checkOutput({tag, "_mreq_hsize"}, val_t'(mem_req_hsize), '0);
      checkOutput({tag, "_mreq_hprot"}, val_t'(mem_req_hprot), '0);
      checkOutput({tag, "_mreq_addr"}, val_t'(mem_req_addr), '0);
      checkOutput({tag, "_mreq_wdata"}, val_t'(mem_req_wdata), '0);
      checkOutput({tag, "_mreq_last"}, val_t'(mem_req_last), '0);
      checkOutput({tag, "_mrsp_ready"}, val_t'(mem_rsp_ready), '0);
      checkOutput({tag, "_stat_rd"}, val_t'(stat_rd_cnt), '0);
      checkOutput({tag, "_stat_wr"}, val_t'(stat_wr_cnt), '0);
   endtask

   // Asserts reset off the clock edge and checks outputs before any edge arrives.
   task automatic applyReset(input string tag);
      rst = 1'b0;
      llc_mem_req_valid = 1'b0;
      mem_req_ready     = 1'b0;
      mem_rsp_valid     = 1'b0;
      llc_mem_rsp_ready = 1'b0;
      #1;
      expWrCnt = 0;
      expRdCnt = 0;
      checkResetOutputs(tag);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   // Issues one line write; abortAt >= 0 resets the DUT after that many beats.
   task automatic applyStimulus_write(input logic [LINE_ADDR_BITS-1:0] addr, input val_t line,
                                      input int readyPct, input int abortAt);
      int beat   = 0;
      int cycles = 0;
      llc_mem_req_valid       = 1'b1;
      llc_mem_req_data_hwrite = 1'b1;
      llc_mem_req_data_addr   = addr;
      llc_mem_req_data_line   = line;
      llc_mem_req_data_hprot  = 2'($urandom);
      llc_mem_req_data_hsize  = 3'($urandom);
      checkOutput("wr_accept_ready", val_t'(llc_mem_req_ready), val_t'(1));
      tick();
      llc_mem_req_valid     = 1'b0;
      llc_mem_req_data_line = randLine();
      while (beat < WORDS_PER_LINE && cycles < 100) begin
         if (beat == abortAt) begin
            applyReset("wr_abort");
            return;
         end
         mem_req_ready = ($urandom_range(0, 99) < readyPct);
         checkOutput("wr_valid",  val_t'(mem_req_valid), val_t'(1));
         checkOutput("wr_addr",   val_t'(mem_req_addr), val_t'(addr * 32 + beat * 8));
         checkOutput("wr_wdata",  val_t'(mem_req_wdata), val_t'(line[beat*WORD_BITS +: WORD_BITS]));
         checkOutput("wr_last",   val_t'(mem_req_last), val_t'(beat == WORDS_PER_LINE - 1));
         checkOutput("wr_hwrite", val_t'(mem_req_hwrite), val_t'(1));
         checkOutput("wr_hsize",  val_t'(mem_req_hsize), val_t'(3));
         checkOutput("wr_busy",   val_t'(llc_mem_req_ready), '0);
         if (mem_req_ready) beat++;
         tick();
         cycles++;
      end
      mem_req_ready = 1'b0;
      checkOutput("wr_beats", val_t'(beat), val_t'(WORDS_PER_LINE));
      if (readyPct >= 100) checkOutput("wr_cycles", val_t'(cycles), val_t'(WORDS_PER_LINE));
      expWrCnt++;
      checkOutput("wr_done_ready", val_t'(llc_mem_req_ready), val_t'(1));
      checkOutput("wr_done_valid", val_t'(mem_req_valid), '0);
   endtask

   // Issues one line read; the memory model returns line words in order with gaps.
   task automatic applyStimulus_read(input logic [LINE_ADDR_BITS-1:0] addr, input val_t line,
                                     input int readyPct, input int minGap, input int maxGap,
                                     input int holdCycles);
      logic [2:0] hs = 3'($urandom);
      logic [1:0] hp = 2'($urandom);
      int  beat    = 0;
      int  cycles  = 0;
      int  gap;
      bit  reqDone = 1'b0;
      llc_mem_req_valid       = 1'b1;
      llc_mem_req_data_hwrite = 1'b0;
      llc_mem_req_data_addr   = addr;
      llc_mem_req_data_line   = randLine();
      llc_mem_req_data_hsize  = hs;
      llc_mem_req_data_hprot  = hp;
      checkOutput("rd_accept_ready", val_t'(llc_mem_req_ready), val_t'(1));
      tick();
      llc_mem_req_valid = 1'b0;
      while (!reqDone && cycles < 100) begin
         mem_req_ready = ($urandom_range(0, 99) < readyPct);
         checkOutput("rd_req_valid",  val_t'(mem_req_valid), val_t'(1));
         checkOutput("rd_req_addr",   val_t'(mem_req_addr), val_t'(addr * 32));
         checkOutput("rd_req_last",   val_t'(mem_req_last), val_t'(1));
         checkOutput("rd_req_hwrite", val_t'(mem_req_hwrite), '0);
         checkOutput("rd_req_hsize",  val_t'(mem_req_hsize), val_t'(hs));
         checkOutput("rd_req_hprot",  val_t'(mem_req_hprot), val_t'(hp));
         checkOutput("rd_req_wdata",  val_t'(mem_req_wdata), '0);
         if (mem_req_ready) reqDone = 1'b1;
         tick();
         cycles++;
      end
      mem_req_ready = 1'b0;
      checkOutput("rd_req_done", val_t'(reqDone), val_t'(1));
      cycles = 0;
      gap    = $urandom_range(minGap, maxGap);
      while (beat < WORDS_PER_LINE && cycles < 200) begin
         checkOutput("rd_no_extra_req", val_t'(mem_req_valid), '0);
         checkOutput("rd_mrsp_ready",   val_t'(mem_rsp_ready), val_t'(1));
         checkOutput("rd_rsp_early",    val_t'(llc_mem_rsp_valid), '0);
         if (gap > 0) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = {$urandom, $urandom};
            gap--;
         end else begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = line[beat*WORD_BITS +: WORD_BITS];
            beat++;
            gap = $urandom_range(minGap, maxGap);
         end
         tick();
         cycles++;
      end
      mem_rsp_valid = 1'b0;
      checkOutput("rd_beats", val_t'(beat), val_t'(WORDS_PER_LINE));
      llc_mem_rsp_ready = 1'b0;
      for (int i = 0; i < holdCycles; i++) begin
         checkOutput("rd_hold_valid", val_t'(llc_mem_rsp_valid), val_t'(1));
         checkOutput("rd_hold_line",  llc_mem_rsp_data_line, line);
         checkOutput("rd_hold_mrsp",  val_t'(mem_rsp_ready), '0);
         tick();
      end
      llc_mem_rsp_ready = 1'b1;
      checkOutput("rd_rsp_valid", val_t'(llc_mem_rsp_valid), val_t'(1));
      checkOutput("rd_rsp_line",  llc_mem_rsp_data_line, line);
      tick();
      llc_mem_rsp_ready = 1'b0;
      expRdCnt++;
      checkOutput("rd_rsp_drop",   val_t'(llc_mem_rsp_valid), '0);
      checkOutput("rd_idle_ready", val_t'(llc_mem_req_ready), val_t'(1));
   endtask

   task automatic applyStimulus_spurious(input int nCycles);
      for (int i = 0; i < nCycles; i++) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = {$urandom, $urandom};
         checkOutput("spur_mrsp_ready", val_t'(mem_rsp_ready), '0);
         checkOutput("spur_req_ready",  val_t'(llc_mem_req_ready), val_t'(1));
         checkOutput("spur_rsp_valid",  val_t'(llc_mem_rsp_valid), '0);
         tick();
      end
      mem_rsp_valid = 1'b0;
   endtask

   initial begin
      rst                     = 1'b1;
      llc_mem_req_valid       = 1'b0;
      llc_mem_req_data_hwrite = 1'b0;
      llc_mem_req_data_hsize  = '0;
      llc_mem_req_data_hprot  = '0;
      llc_mem_req_data_addr   = '0;
      llc_mem_req_data_line   = '0;
      llc_mem_rsp_ready       = 1'b0;
      mem_req_ready           = 1'b0;
      mem_rsp_valid           = 1'b0;
      mem_rsp_data            = '0;
      #2;
      applyReset("por");

      $display("[TB] directed write / read");
      applyStimulus_write(26'h100, {64'h3, 64'h2, 64'h1, 64'h0}, 100, -1);
      applyStimulus_read(26'h5, {64'hD, 64'hC, 64'hB, 64'hA}, 100, 2, 2, 3);
      applyStimulus_write(26'h2A5, randLine(), 50, -1);

      $display("[TB] spurious read beat while idle");
      applyStimulus_spurious(3);
      applyStimulus_read(26'h33, randLine(), 70, 0, 3, 1);

      $display("[TB] reset in the middle of a write");
      applyStimulus_write(26'h77, randLine(), 100, 2);
      applyStimulus_write(26'h78, randLine(), 100, -1);

      $display("[TB] counter scenario: 3 writes, 2 reads");
      applyReset("stat");
      for (int i = 0; i < 3; i++) applyStimulus_write(26'($urandom), randLine(), 60, -1);
      for (int i = 0; i < 2; i++) applyStimulus_read(26'($urandom), randLine(), 60, 0, 2, 0);
      checkOutput("stat_wr_cnt", val_t'(stat_wr_cnt), expStatWr());
      checkOutput("stat_rd_cnt", val_t'(stat_rd_cnt), expStatRd());

      $display("[TB] randomized transactions");
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 1) == 1)
            applyStimulus_write(26'($urandom), randLine(), $urandom_range(30, 100), -1);
         else
            applyStimulus_read(26'($urandom), randLine(), $urandom_range(30, 100),
                               0, $urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) applyStimulus_spurious($urandom_range(1, 2));
      end
      checkOutput("stat_wr_final", val_t'(stat_wr_cnt), expStatWr());
      checkOutput("stat_rd_final", val_t'(stat_rd_cnt), expStatRd());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
